// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one uart_send transmitter
// among NUM_REQ byte sources. Grants one requester at a time, raises
// uart_en to start a frame, follows uart_tx_busy through the frame and
// reports per-requester completion (done) or a start timeout (err).
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for a request while the transmitter is not busy
// S_START | uart_en held high, waiting for uart_tx_busy to rise
// S_SEND  | frame in flight, waiting for uart_tx_busy to fall
// S_GAP   | one cycle with uart_en low so the next start sees a fresh edge
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int BUSY_TIMEOUT = 8
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*8-1:0] din,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [NUM_REQ-1:0]   done,
    output logic                 err,
    output logic                 idle,
    output logic                 uart_en,
    output logic [7:0]           uart_din,
    input  logic                 uart_tx_busy
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_SEND  = 2'd2;
    localparam logic [1:0] S_GAP   = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BUSY_TIMEOUT);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);
    localparam logic [PTR_W:0]   NUM_EXT  = (PTR_W + 1)'(NUM_REQ);

    logic [1:0]             state_q, state_d;
    logic [NUM_REQ-1:0]     gnt_q, gnt_d;
    logic [NUM_REQ-1:0]     done_q, done_d;
    logic                   err_q, err_d;
    logic                   en_q, en_d;
    logic [7:0]             din_q, din_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [PTR_W-1:0]       owner_q, owner_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic [NUM_REQ-1:0][7:0] din_pk;
    logic                    sel_found;
    logic [PTR_W-1:0]        sel_idx;
    logic [PTR_W:0]          cand;

    assign din_pk = din;

    // Round-robin search: first set req bit at or above the pointer, wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr_q} + (PTR_W + 1)'(k);
            if (cand >= NUM_EXT) begin
                cand = cand - NUM_EXT;
            end
            if (!sel_found && req[cand[PTR_W-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[PTR_W-1:0];
            end
        end
    end

    // Next-state and registered-output logic for the sequencing FSM.
    always_comb begin
        state_d = state_q;
        gnt_d   = '0;
        done_d  = '0;
        err_d   = 1'b0;
        en_d    = en_q;
        din_d   = din_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                // A busy transmitter here is a leftover frame; never start over it.
                if (!uart_tx_busy && sel_found) begin
                    state_d = S_START;
                    gnt_d   = NUM_REQ'(1) << sel_idx;
                    din_d   = din_pk[sel_idx];
                    en_d    = 1'b1;
                    owner_d = sel_idx;
                    ptr_d   = (sel_idx == PTR_LAST) ? '0 : sel_idx + 1'b1;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (uart_tx_busy) begin
                    state_d = S_SEND;
                    en_d    = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_GAP;
                    en_d    = 1'b0;
                    err_d   = 1'b1;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SEND: begin
                if (!uart_tx_busy) begin
                    state_d = S_GAP;
                    done_d  = NUM_REQ'(1) << owner_q;
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
                en_d    = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                en_d    = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any frame without done/err.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            en_q    <= 1'b0;
            din_q   <= '0;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            en_q    <= en_d;
            din_q   <= din_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign err      = err_q;
    assign uart_en  = en_q;
    assign uart_din = din_q;
    assign idle     = (state_q == S_IDLE);

endmodule
